// File: rtl/rx_frame_writer_pkg.sv
// Shared NTS RX constants: counter and byte-count widths and the legal byte-mask table.
package rx_frame_writer_pkg;

  localparam int unsigned CNT_W      = 32;
  localparam int unsigned BCNT_W     = 4;
  localparam int unsigned MASK_TBL_N = 8;

  // Entry i is the mask of a word carrying i+1 bytes, packed from the LSB.
  localparam logic [MASK_TBL_N-1:0][7:0] LEGAL_MASK = {
    8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01
  };

endpackage

// File: rtl/rx_mask_decode.sv
// Byte-mask classifier: legality against the packed-from-LSB table, all-ones flag and byte count.
module rx_mask_decode
  import rx_frame_writer_pkg::*;
#(
  parameter int unsigned MASK_W = 8
) (
  input  logic [MASK_W-1:0] mask,
  output logic              legal_c,
  output logic              full_c,
  output logic [BCNT_W-1:0] popcnt_c
);

  always_comb begin
    legal_c = 1'b0;
    for (int unsigned i = 0; i < MASK_TBL_N; i++) begin
      if (mask == MASK_W'(LEGAL_MASK[i])) legal_c = 1'b1;
    end
  end

  always_comb begin
    popcnt_c = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      popcnt_c = popcnt_c + BCNT_W'(mask[i]);
    end
  end

  assign full_c = &mask;

endmodule

// File: rtl/rx_frame_writer.sv
// Writes received MAC frames into a single-frame BRAM buffer and hands complete good frames to a consumer.
module rx_frame_writer
  import rx_frame_writer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    i_clk,
  input  logic                    i_areset_n,
  input  logic                    i_rx_start,
  input  logic [DATA_WIDTH/8-1:0] i_rx_data_valid,
  input  logic [DATA_WIDTH-1:0]   i_rx_data,
  input  logic                    i_rx_good,
  input  logic                    i_rx_bad,
  input  logic                    i_release,
  output logic                    o_ram_en,
  output logic                    o_ram_we,
  output logic [ADDR_WIDTH-1:0]   o_ram_addr,
  output logic [DATA_WIDTH-1:0]   o_ram_wdata,
  output logic                    o_frame_ready,
  output logic [ADDR_WIDTH:0]     o_frame_words,
  output logic [BCNT_W-1:0]       o_frame_last_bytes,
  output logic [CNT_W-1:0]        o_cnt_good,
  output logic [CNT_W-1:0]        o_cnt_drop
);

  localparam int unsigned MASK_W = DATA_WIDTH / 8;
  localparam int unsigned WCNT_W = ADDR_WIDTH + 1;
  localparam logic [WCNT_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_DISCARD,
    S_FULL,
    S_FULL_DISCARD
  } state_t;

  state_t                  state_q, state_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic                    partial_q, partial_d;
  logic [BCNT_W-1:0]       last_bytes_q, last_bytes_d;
  logic                    ram_en_q, ram_en_d;
  logic                    ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic                    ready_q, ready_d;
  logic [WCNT_W-1:0]       words_q, words_d;
  logic [BCNT_W-1:0]       lastb_q, lastb_d;
  logic [CNT_W-1:0]        cnt_good_q, cnt_good_d;
  logic [CNT_W-1:0]        cnt_drop_q, cnt_drop_d;

  logic                    legal_c;
  logic                    full_c;
  logic [BCNT_W-1:0]       popcnt_c;
  logic                    word_c;
  logic                    end_c;
  logic                    begin_frame_c;
  logic                    append_c;

  rx_mask_decode #(
    .MASK_W (MASK_W)
  ) u_mask_decode (
    .mask     (i_rx_data_valid),
    .legal_c  (legal_c),
    .full_c   (full_c),
    .popcnt_c (popcnt_c)
  );

  assign word_c = |i_rx_data_valid;
  assign end_c  = i_rx_good | i_rx_bad;

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      partial_q    <= 1'b0;
      last_bytes_q <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ready_q      <= 1'b0;
      words_q      <= '0;
      lastb_q      <= '0;
      cnt_good_q   <= '0;
      cnt_drop_q   <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      partial_q    <= partial_d;
      last_bytes_q <= last_bytes_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ready_q      <= ready_d;
      words_q      <= words_d;
      lastb_q      <= lastb_d;
      cnt_good_q   <= cnt_good_d;
      cnt_drop_q   <= cnt_drop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    partial_d     = partial_q;
    last_bytes_d  = last_bytes_q;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    ready_d       = ready_q;
    words_d       = words_q;
    lastb_d       = lastb_q;
    cnt_good_d    = cnt_good_q;
    cnt_drop_d    = cnt_drop_q;
    begin_frame_c = 1'b0;
    append_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_rx_start && word_c) begin_frame_c = 1'b1;
      end

      S_WRITE: begin
        if (i_rx_start && word_c) begin
          // A new start with no end abandons the frame in progress.
          cnt_drop_d    = cnt_drop_q + CNT_W'(1);
          begin_frame_c = 1'b1;
        end else if (end_c) begin
          if (i_rx_bad) begin
            cnt_drop_d = cnt_drop_q + CNT_W'(1);
            state_d    = S_IDLE;
          end else begin
            ready_d    = 1'b1;
            words_d    = wcnt_q;
            lastb_d    = last_bytes_q;
            cnt_good_d = cnt_good_q + CNT_W'(1);
            state_d    = S_FULL;
          end
        end else if (word_c) begin
          // Overflow, illegal mask, or a word after a short word all poison the frame.
          if ((wcnt_q == DEPTH) || !legal_c || partial_q) state_d = S_DISCARD;
          else                                            append_c = 1'b1;
        end
      end

      S_DISCARD: begin
        if (i_rx_start && word_c) begin
          cnt_drop_d    = cnt_drop_q + CNT_W'(1);
          begin_frame_c = 1'b1;
        end else if (end_c) begin
          cnt_drop_d = cnt_drop_q + CNT_W'(1);
          state_d    = S_IDLE;
        end
      end

      S_FULL: begin
        if (i_release) begin
          ready_d = 1'b0;
          if (i_rx_start && word_c) begin_frame_c = 1'b1;
          else                      state_d       = S_IDLE;
        end else if (i_rx_start && word_c) begin
          state_d = S_FULL_DISCARD;
        end
      end

      S_FULL_DISCARD: begin
        if (end_c) begin
          cnt_drop_d = cnt_drop_q + CNT_W'(1);
          if (i_release) begin
            ready_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_FULL;
          end
        end else if (i_release) begin
          ready_d = 1'b0;
          state_d = S_DISCARD;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (begin_frame_c) begin
      if (legal_c) begin
        ram_en_d     = 1'b1;
        ram_we_d     = 1'b1;
        ram_addr_d   = '0;
        ram_wdata_d  = i_rx_data;
        wcnt_d       = WCNT_W'(1);
        partial_d    = !full_c;
        last_bytes_d = popcnt_c;
        state_d      = S_WRITE;
      end else begin
        state_d = S_DISCARD;
      end
    end

    if (append_c) begin
      ram_en_d     = 1'b1;
      ram_we_d     = 1'b1;
      ram_addr_d   = wcnt_q[ADDR_WIDTH-1:0];
      ram_wdata_d  = i_rx_data;
      wcnt_d       = wcnt_q + WCNT_W'(1);
      partial_d    = !full_c;
      last_bytes_d = popcnt_c;
    end
  end

  assign o_ram_en           = ram_en_q;
  assign o_ram_we           = ram_we_q;
  assign o_ram_addr         = ram_addr_q;
  assign o_ram_wdata        = ram_wdata_q;
  assign o_frame_ready      = ready_q;
  assign o_frame_words      = words_q;
  assign o_frame_last_bytes = lastb_q;
  assign o_cnt_good         = cnt_good_q;
  assign o_cnt_drop         = cnt_drop_q;

endmodule

// File: tb/tb_rx_frame_writer.sv
// Bench for rx_frame_writer: per-cycle vector table with a RAM-write scoreboard, plus overflow and reset sequences.
module tb_rx_frame_writer;

  logic        i_clk = 1'b0;
  logic        rst_n, rst2_n;
  logic        rx_start, rx_good, rx_bad, rel;
  logic [7:0]  rx_valid;
  logic [63:0] rx_data;

  logic        ram_en, ram_we, frame_ready;
  logic [7:0]  ram_addr;
  logic [63:0] ram_wdata;
  logic [8:0]  frame_words;
  logic [3:0]  frame_lb;
  logic [31:0] cnt_good, cnt_drop;

  logic        d2_ram_en, d2_ram_we, d2_ready;
  logic [1:0]  d2_ram_addr;
  logic [63:0] d2_ram_wdata;
  logic [2:0]  d2_words;
  logic [3:0]  d2_lb;
  logic [31:0] d2_good, d2_drop;

  always #5 i_clk = ~i_clk;

  rx_frame_writer #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) dut (
    .i_clk(i_clk), .i_areset_n(rst_n), .i_rx_start(rx_start), .i_rx_data_valid(rx_valid),
    .i_rx_data(rx_data), .i_rx_good(rx_good), .i_rx_bad(rx_bad), .i_release(rel),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .o_frame_ready(frame_ready), .o_frame_words(frame_words), .o_frame_last_bytes(frame_lb),
    .o_cnt_good(cnt_good), .o_cnt_drop(cnt_drop));

  rx_frame_writer #(.ADDR_WIDTH(2), .DATA_WIDTH(64)) dut2 (
    .i_clk(i_clk), .i_areset_n(rst2_n), .i_rx_start(rx_start), .i_rx_data_valid(rx_valid),
    .i_rx_data(rx_data), .i_rx_good(rx_good), .i_rx_bad(rx_bad), .i_release(rel),
    .o_ram_en(d2_ram_en), .o_ram_we(d2_ram_we), .o_ram_addr(d2_ram_addr), .o_ram_wdata(d2_ram_wdata),
    .o_frame_ready(d2_ready), .o_frame_words(d2_words), .o_frame_last_bytes(d2_lb),
    .o_cnt_good(d2_good), .o_cnt_drop(d2_drop));

  typedef struct {
    logic        start;
    logic [7:0]  mask;
    logic        good, bad, rel;
    logic        wr;
    logic [7:0]  addr;
    logic        rdy;
    logic [8:0]  words;
    logic [3:0]  lb;
    logic [31:0] ng, nd;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[30];

  function automatic vec_t v(input logic st, input logic [7:0] m, input logic g, input logic b,
                             input logic r, input logic w, input logic [7:0] a, input logic rd,
                             input logic [8:0] wo, input logic [3:0] l, input logic [31:0] ng,
                             input logic [31:0] nd);
    vec_t t;
    t.start = st; t.mask = m; t.good = g; t.bad = b; t.rel = r; t.wr = w; t.addr = a;
    t.rdy = rd; t.words = wo; t.lb = l; t.ng = ng; t.nd = nd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle from the current negedge, then check outputs at the following negedge.
  task automatic step(input string tag, input vec_t t);
    wr_t e;
    rx_start = t.start; rx_valid = t.mask; rx_good = t.good; rx_bad = t.bad; rel = t.rel;
    rx_data  = {8{8'(n_vec)}} ^ 64'h0123_4567_89AB_CDEF;
    if (t.wr) begin
      e.addr = t.addr; e.data = rx_data;
      exp_q.push_back(e);
    end
    n_vec++;
    @(posedge i_clk);
    @(negedge i_clk);
    if (ram_en) begin
      if (exp_q.size() == 0) chk({tag, " unexpected write"}, 64'(ram_addr), 64'hDEAD);
      else begin
        e = exp_q.pop_front();
        chk({tag, " we"}, 64'(ram_we), 64'h1);
        chk({tag, " addr"}, 64'(ram_addr), 64'(e.addr));
        chk({tag, " wdata"}, ram_wdata, e.data);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, " missing write"}, 64'(ram_en), 64'h1);
    end
    chk({tag, " ready"}, 64'(frame_ready), 64'(t.rdy));
    chk({tag, " words"}, 64'(frame_words), 64'(t.words));
    chk({tag, " last_bytes"}, 64'(frame_lb), 64'(t.lb));
    chk({tag, " cnt_good"}, 64'(cnt_good), 64'(t.ng));
    chk({tag, " cnt_drop"}, 64'(cnt_drop), 64'(t.nd));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ram_en"}, 64'(ram_en), 64'h0);
    chk({tag, " ram_we"}, 64'(ram_we), 64'h0);
    chk({tag, " ram_addr"}, 64'(ram_addr), 64'h0);
    chk({tag, " ram_wdata"}, ram_wdata, 64'h0);
    chk({tag, " ready"}, 64'(frame_ready), 64'h0);
    chk({tag, " words"}, 64'(frame_words), 64'h0);
    chk({tag, " last_bytes"}, 64'(frame_lb), 64'h0);
    chk({tag, " cnt_good"}, 64'(cnt_good), 64'h0);
    chk({tag, " cnt_drop"}, 64'(cnt_drop), 64'h0);
  endtask

  initial begin
    //             st  mask  g  b  r  wr addr rdy wrd lb ng nd
    tbl[0]  = v(1, 8'hFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);  // good 3-word frame
    tbl[1]  = v(0, 8'hFF, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[2]  = v(0, 8'h0F, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    tbl[3]  = v(0, 8'h00, 1, 0, 0, 0, 0, 1, 3, 4, 1, 0);
    tbl[4]  = v(1, 8'hFF, 0, 0, 0, 0, 0, 1, 3, 4, 1, 0);  // second frame while full
    tbl[5]  = v(0, 8'hFF, 0, 0, 0, 0, 0, 1, 3, 4, 1, 0);
    tbl[6]  = v(0, 8'h00, 1, 0, 0, 0, 0, 1, 3, 4, 1, 1);
    tbl[7]  = v(0, 8'h00, 0, 0, 1, 0, 0, 0, 3, 4, 1, 1);
    tbl[8]  = v(1, 8'h03, 0, 0, 0, 1, 0, 0, 3, 4, 1, 1);  // 1-word frame
    tbl[9]  = v(0, 8'h00, 1, 0, 0, 0, 0, 1, 1, 2, 2, 1);
    tbl[10] = v(1, 8'hFF, 0, 0, 1, 1, 0, 0, 1, 2, 2, 1);  // release + start together
    tbl[11] = v(0, 8'h07, 0, 0, 0, 1, 1, 0, 1, 2, 2, 1);
    tbl[12] = v(0, 8'h00, 1, 0, 0, 0, 0, 1, 2, 3, 3, 1);
    tbl[13] = v(0, 8'h00, 0, 0, 1, 0, 0, 0, 2, 3, 3, 1);
    tbl[14] = v(1, 8'hFF, 0, 0, 0, 1, 0, 0, 2, 3, 3, 1);  // bad mask mid-frame
    tbl[15] = v(0, 8'h05, 0, 0, 0, 0, 0, 0, 2, 3, 3, 1);
    tbl[16] = v(0, 8'hFF, 0, 0, 0, 0, 0, 0, 2, 3, 3, 1);
    tbl[17] = v(0, 8'h00, 0, 1, 0, 0, 0, 0, 2, 3, 3, 2);
    tbl[18] = v(1, 8'h3F, 0, 0, 0, 1, 0, 0, 2, 3, 3, 2);  // short word then another word
    tbl[19] = v(0, 8'hFF, 0, 0, 0, 0, 0, 0, 2, 3, 3, 2);
    tbl[20] = v(0, 8'h00, 1, 0, 0, 0, 0, 0, 2, 3, 3, 3);
    tbl[21] = v(1, 8'hFF, 0, 0, 0, 1, 0, 0, 2, 3, 3, 3);  // restart without end
    tbl[22] = v(0, 8'hFF, 0, 0, 0, 1, 1, 0, 2, 3, 3, 3);
    tbl[23] = v(1, 8'h01, 0, 0, 0, 1, 0, 0, 2, 3, 3, 4);
    tbl[24] = v(0, 8'h00, 1, 1, 0, 0, 0, 0, 2, 3, 3, 5);  // good+bad counts as bad
    tbl[25] = v(0, 8'h00, 1, 0, 0, 0, 0, 0, 2, 3, 3, 5);  // stray end in idle
    tbl[26] = v(0, 8'h00, 0, 0, 1, 0, 0, 0, 2, 3, 3, 5);  // stray release in idle
    tbl[27] = v(0, 8'hFF, 0, 0, 0, 0, 0, 0, 2, 3, 3, 5);  // word without start
    tbl[28] = v(1, 8'h1F, 0, 0, 0, 1, 0, 0, 2, 3, 3, 5);
    tbl[29] = v(0, 8'h00, 0, 1, 0, 0, 0, 0, 2, 3, 3, 6);

    rst_n = 1'b0; rst2_n = 1'b0;
    rx_start = 0; rx_valid = '0; rx_data = '0; rx_good = 0; rx_bad = 0; rel = 0;
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 30; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Overflow: 5 words into the depth-4 instance; the deep instance accepts them.
    rst2_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step($sformatf("ovf%0d", k), v(k == 0, 8'hFF, 0, 0, 0, 1, 8'(k), 0, 2, 3, 3, 6));
      chk($sformatf("ovf%0d d2 en", k), 64'(d2_ram_en), 64'(k < 4));
      if (k < 4) chk($sformatf("ovf%0d d2 addr", k), 64'(d2_ram_addr), 64'(k));
    end
    step("ovf_end", v(0, 8'h00, 1, 0, 0, 0, 0, 1, 5, 8, 4, 6));
    chk("ovf d2 ready", 64'(d2_ready), 64'h0);
    chk("ovf d2 cnt_drop", 64'(d2_drop), 64'h1);
    chk("ovf d2 cnt_good", 64'(d2_good), 64'h0);
    step("ovf_rel", v(0, 8'h00, 0, 0, 1, 0, 0, 0, 5, 8, 4, 6));

    // Reset mid-frame: outputs clear without a clock edge; the tail of the frame is ignored.
    step("rst0", v(1, 8'hFF, 0, 0, 0, 1, 0, 0, 5, 8, 4, 6));
    step("rst1", v(0, 8'hFF, 0, 0, 0, 1, 1, 0, 5, 8, 4, 6));
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge i_clk);
    rst_n = 1'b1;
    step("rst2", v(0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("rst3", v(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("rst4", v(1, 8'h07, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step("rst5", v(0, 8'h00, 1, 0, 0, 0, 0, 1, 1, 3, 1, 0));

    chk("scoreboard drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
